// File: rtl/gm_led_7doan_pkg.sv
// Shared constants for the hex-digit 7-segment decoder.
// Patterns are active-low (common anode), bit order {g,f,e,d,c,b,a}.
// B and D are drawn lower-case so they stay distinct from 8 and 0.
package gm_led_7doan_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;

    // All segments dark on a common-anode digit.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/gm_led_7doan_hex_to_seg.sv
// Purpose: combinational 4-bit hex digit to active-low 7-segment lookup.
// Latency: zero cycles, pure combinational.
// Backpressure: none; output is a pure function of the input.
module hex_to_seg
    import gm_led_7doan_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup; anything unresolvable (X/Z) falls back to a dark digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gm_led_7doan.sv
// Purpose: registered hex digit to 7-segment driver, polarity selectable.
// Latency: one clk; so_gma sampled at edge N shows on sseg after edge N.
// Backpressure: none; a new digit is accepted every cycle, reset blanks at once.
module gm_led_7doan
    import gm_led_7doan_pkg::*;
#(
    parameter int unsigned COMMON_ANODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       so_gma,
    output logic [SEG_W-1:0] sseg
);

    // Dark pattern for the selected polarity; a cathode digit is dark at all-zero.
    localparam logic [SEG_W-1:0] BLANK_PAT = (COMMON_ANODE != 0) ? SEG_BLANK : ~SEG_BLANK;

    logic [SEG_W-1:0] seg_raw;
    logic [SEG_W-1:0] sseg_d;
    logic [SEG_W-1:0] sseg_q;

    hex_to_seg u_hex_to_seg (
        .hex_i (so_gma),
        .seg_o (seg_raw)
    );

    // Apply polarity: the lookup is active-low, a cathode digit needs it flipped.
    always_comb begin
        sseg_d = seg_raw;
        if (COMMON_ANODE == 0) begin
            sseg_d = ~seg_raw;
        end
    end

    // Output register; reset blanks the digit without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_q <= BLANK_PAT;
        end else begin
            sseg_q <= sseg_d;
        end
    end

    assign sseg = sseg_q;

endmodule

// File: tb/tb_gm_led_7doan.sv
// Directed bench for gm_led_7doan: anode build plus a cathode build on shared inputs.
// Inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
// Expected patterns are hand-transcribed from the decode table.
module tb_gm_led_7doan;

    logic       clk;
    logic       rst;
    logic [3:0] so_gma;
    logic [6:0] sseg;
    logic [6:0] sseg_cc;

    int n_vec;
    int n_err;

    logic [6:0] exp_tab [16];

    gm_led_7doan #(.COMMON_ANODE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .so_gma (so_gma),
        .sseg   (sseg)
    );

    gm_led_7doan #(.COMMON_ANODE(0)) dut_cc (
        .clk    (clk),
        .rst    (rst),
        .so_gma (so_gma),
        .sseg   (sseg_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_seg(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] val;
        logic [3:0] prev;

        n_vec  = 0;
        n_err  = 0;
        exp_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst    = 1'b0;
        so_gma = 4'h0;

        // Reset with no clock edge yet, then held for three clocks.
        #1;
        so_gma = 4'h8;
        rst    = 1'b1;
        #1;
        chk_seg("rst_async", sseg, 7'h7F);
        chk_seg("rst_async_cc", sseg_cc, 7'h00);
        repeat (3) @(posedge clk);
        #1;
        chk_seg("rst_hold", sseg, 7'h7F);
        chk_seg("rst_hold_cc", sseg_cc, 7'h00);

        // Walk 0..F, one digit per clock, both polarities.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            so_gma = 4'(i);
            @(posedge clk);
            #1;
            chk_seg($sformatf("walk_%h", i), sseg, exp_tab[i]);
            chk_seg($sformatf("walk_cc_%h", i), sseg_cc, ~exp_tab[i]);
        end

        // Slow counter E, F, 0 stepping every 5 clocks across the wrap.
        prev = 4'hF;
        for (int k = 0; k < 3; k++) begin
            val = 4'(4'hE + k);
            @(negedge clk);
            so_gma = val;
            #1;
            chk_seg($sformatf("cnt_lag_%h", val), sseg, exp_tab[prev]);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                chk_seg($sformatf("cnt_%h_c%0d", val, c), sseg, exp_tab[val]);
            end
            prev = val;
        end

        // Input changes between edges must not reach the output early.
        @(negedge clk);
        so_gma = 4'h3;
        @(posedge clk);
        #1;
        chk_seg("mid_3", sseg, 7'h30);
        #2;
        so_gma = 4'h7;
        #1;
        chk_seg("mid_hold", sseg, 7'h30);
        @(posedge clk);
        #1;
        chk_seg("mid_7", sseg, 7'h78);

        // Reset mid-stream blanks immediately, recovers on the next edge.
        @(negedge clk);
        so_gma = 4'h2;
        @(posedge clk);
        #1;
        chk_seg("pre_rst_2", sseg, 7'h24);
        #2;
        rst = 1'b1;
        #1;
        chk_seg("rst_mid", sseg, 7'h7F);
        chk_seg("rst_mid_cc", sseg_cc, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_seg("rst_rel_hold", sseg, 7'h7F);
        @(posedge clk);
        #1;
        chk_seg("post_rst_2", sseg, 7'h24);
        chk_seg("post_rst_2_cc", sseg_cc, 7'h5B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
